// File: rtl/pwm_bank_if.sv
// Byte-wide register write port between the SPI register peripheral and pwm_bank.
// The SPI side is the master; pwm_bank is the slave.
interface pwm_bank_if #(
   parameter int ADDR_W = 7
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data
   );

   modport slave (
      input wr_en,
      input wr_addr,
      input wr_data
   );
endinterface

// File: rtl/pwm_bank.sv
// N-channel PWM engine: write-only register map, shared prescaled 8-bit period counter,
// double-buffered per-channel duty and registered channel outputs.
module pwm_bank #(
   parameter int NUM_CH  = 16,
   parameter int ADDR_W  = 7,
   parameter int PRESC_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   pwm_bank_if.slave         wr,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              period_start,
   output logic [7:0]        active_duty_dbg
);

   localparam int NUM_BYTES = NUM_CH / 8;

   logic [PRESC_W-1:0] prescale_reg;
   logic [PRESC_W-1:0] pre_cnt_reg;
   logic [7:0]         pcnt_reg;
   logic               period_start_reg;
   logic [NUM_CH-1:0]  pwm_out_reg;
   logic [NUM_CH-1:0]  pwm_next;

   logic [7:0] out_en_reg [NUM_BYTES];
   logic [7:0] pwm_en_reg [NUM_BYTES];
   logic [7:0] shadow_reg [NUM_CH];
   logic [7:0] active_reg [NUM_CH];

   logic tick;
   logic wrap;
   logic presc_hit;

   // ">=" rather than "==" so that lowering prescale below pre_cnt still ticks at once
   assign tick      = (pre_cnt_reg >= prescale_reg);
   assign wrap      = tick && (pcnt_reg == 8'hFF);
   assign presc_hit = wr.wr_en && (wr.wr_addr == ADDR_W'(16));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescale_reg     <= '0;
         pre_cnt_reg      <= '0;
         pcnt_reg         <= '0;
         period_start_reg <= 1'b0;
         pwm_out_reg      <= '0;
      end else begin
         if (presc_hit) begin
            prescale_reg <= PRESC_W'(wr.wr_data);
         end
         if (tick) begin
            pre_cnt_reg <= '0;
            pcnt_reg    <= pcnt_reg + 8'd1;
         end else begin
            pre_cnt_reg <= pre_cnt_reg + PRESC_W'(1);
         end
         period_start_reg <= wrap;
         pwm_out_reg      <= pwm_next;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
         logic oe_hit;
         logic pe_hit;

         assign oe_hit = wr.wr_en && (wr.wr_addr == ADDR_W'(gi));
         assign pe_hit = wr.wr_en && (wr.wr_addr == ADDR_W'(8 + gi));

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               out_en_reg[gi] <= 8'h00;
               pwm_en_reg[gi] <= 8'h00;
            end else begin
               if (oe_hit) begin
                  out_en_reg[gi] <= wr.wr_data;
               end
               if (pe_hit) begin
                  pwm_en_reg[gi] <= wr.wr_data;
               end
            end
         end
      end

      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic duty_hit;
         logic oe;
         logic pe;

         assign duty_hit = wr.wr_en && (wr.wr_addr == ADDR_W'(32 + gi));
         assign oe       = out_en_reg[gi / 8][gi % 8];
         assign pe       = pwm_en_reg[gi / 8][gi % 8];

         // A duty write landing on the wrap cycle goes straight into the active register
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               shadow_reg[gi] <= 8'h00;
               active_reg[gi] <= 8'h00;
            end else begin
               if (duty_hit) begin
                  shadow_reg[gi] <= wr.wr_data;
               end
               if (wrap) begin
                  active_reg[gi] <= duty_hit ? wr.wr_data : shadow_reg[gi];
               end
            end
         end

         assign pwm_next[gi] = !oe                       ? 1'b0 :
                               !pe                       ? 1'b1 :
                               (active_reg[gi] == 8'hFF) ? 1'b1 :
                               (pcnt_reg < active_reg[gi]);
      end
   endgenerate

   assign pwm_out         = pwm_out_reg;
   assign period_start    = period_start_reg;
   assign active_duty_dbg = active_reg[0];

endmodule
